// File: rtl/imem_fetch_if.sv
// Fetch-unit bus bundle: redirect/fetch control, instruction memory port and
// the decoupled instruction output toward decode.
interface imem_fetch_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [23:0] redirect_pc;
  logic [23:0] imem_addr;
  logic [23:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_instr;
  logic [23:0] out_pc;

  // Fetch unit side
  modport slave (
    input  fetch_en, redirect_valid, redirect_pc, imem_data, out_ready,
    output imem_addr, out_valid, out_instr, out_pc
  );

  // Core / memory / decode side
  modport master (
    output fetch_en, redirect_valid, redirect_pc, imem_data, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/imem_fetch.sv
// Instruction fetch: issues one word address per cycle to a 1-cycle-latency
// memory and buffers responses in a 2-entry FIFO. Issue is throttled so that
// buffered + in-flight never exceeds the FIFO depth, so responses never drop.
module imem_fetch #(
  parameter logic [23:0] RESET_PC = 24'h000000,
  parameter int          DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  imem_fetch_if.slave bus
);

  logic [23:0] r_pc;
  logic        r_inflight;
  logic [23:0] r_ipc;
  logic        r_kill;
  logic [1:0]  r_count;
  logic [23:0] r_epc [DEPTH];
  logic [23:0] r_ein [DEPTH];

  logic        w_pop;
  logic        w_issue;
  logic        w_wr;
  logic        w_slot;
  logic [2:0]  w_occ;

  // Occupancy after this edge's pop, counting the response still in flight.
  assign w_pop   = bus.out_valid & bus.out_ready;
  assign w_occ   = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = bus.fetch_en & ~bus.redirect_valid & (w_occ < 3'(DEPTH));
  // A redirect flushes the buffer, so the response landing with it is dropped.
  assign w_wr    = r_inflight & ~r_kill & ~bus.redirect_valid;
  // Write position is behind the head after any simultaneous pop.
  assign w_slot  = ((r_count == 2'd1) & ~w_pop) | (r_count == 2'd2);

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_instr = r_ein[0];
  assign bus.out_pc    = r_epc[0];

  // PC advance, redirect, and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_ipc      <= '0;
      r_kill     <= 1'b0;
    end else begin
      r_kill     <= bus.redirect_valid & w_issue;
      r_inflight <= w_issue;
      if (bus.redirect_valid) r_pc <= bus.redirect_pc;
      else if (w_issue)       r_pc <= r_pc + 24'd1;
      if (w_issue) r_ipc <= r_pc;
    end
  end

  // Output FIFO: entry 0 is the head; pop shifts, write lands behind head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_epc[i] <= '0;
        r_ein[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_epc[0] <= r_epc[1];
        r_ein[0] <= r_ein[1];
      end
      if (w_wr) begin
        r_epc[w_slot] <= r_ipc;
        r_ein[w_slot] <= bus.imem_data;
      end
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_pop};
    end
  end

endmodule
